wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter for the single register-file write port behind the WriteBack stage. It shares that port between the in-order pipeline result (already selected between readData and ALUResult) and results returned by the long-latency unit (multiply/divide). Long-latency results are held in a small FIFO until the port is free. A starvation guard freezes the pipeline so buffered results always drain.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)
- MAX_WAIT, 4, consecutive un-granted cycles of a buffered result before pipeline stall (≥1)

Clock/reset: one clock; reset is asynchronous and active-low.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pipe_we  in  1  pipeline WB write request
- pipe_addr  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline write data (writeData of WB mux)
- lu_valid  in  1  long-latency result valid
- lu_addr  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result data
- lu_ready  out  1  FIFO can accept this cycle
- stall_pipe  out  1  freeze pipeline (hold WB inputs stable)
- pending  out  1  FIFO non-empty
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  ADDR_W  register-file write address (registered)
- rf_data  out  DATA_W  register-file write data (registered)

## Operation
- Push: lu_valid && lu_ready enqueues {lu_addr, lu_data}; lu_valid while !lu_ready is a protocol violation (source must hold).
- lu_ready = (count < FIFO_DEPTH), from registered count; no same-cycle pass-through when full.
- States: NORMAL, STALL. stall_pipe = (state == STALL).
- Grant in NORMAL: pipe_we && pipe_addr != 0 → pipeline; else if pending → FIFO head (pop).
- Grant in STALL: FIFO head always (pop); pipe_we ignored (pipeline is frozen and re-presents).
- Writes to register 0 from either source are dropped: no rf_we. A head with addr 0 is still popped.
- wait_cnt: increments when pending && head not popped; clears on pop or when FIFO empty; saturates at MAX_WAIT.
- NORMAL→STALL when wait_cnt reaches MAX_WAIT, or when count == FIFO_DEPTH with no pop this cycle.
- STALL→NORMAL on the cycle count becomes 0.
- Push and pop in the same cycle: count unchanged; the head advances.
- Ordering: FIFO entries write in arrival order. The hazard unit guarantees the pipeline never targets a register that has a pending FIFO entry; this block does not check for it.

## Timing
- Reset (async assert): rf_we=0, rf_addr=0, rf_data=0, stall_pipe=0, pending=0, lu_ready=1, count=0, wait_cnt=0, state=NORMAL. FIFO contents are discarded mid-operation.
- Pipeline latency: pipe_we at cycle t → rf_we/rf_addr/rf_data at t+1.
- Long-latency latency: push at t → earliest rf_we at t+2 (pop at t+1, registered output at t+2).
- stall_pipe asserts the cycle after the NORMAL→STALL condition. It deasserts the cycle after the last pop.
- rf_we is high for exactly one cycle per granted non-zero write. rf_addr/rf_data hold their last value when rf_we=0.
- Maximum wait of a FIFO head before it writes: MAX_WAIT + 1 cycles.

## Test plan
- Reset: rst_n=0 mid-stream with 2 entries buffered → all outputs at reset values immediately; pending=0 and lu_ready=1 after release.
- Pipeline only: pipe_we=1, addr=8, data=0x00000001, then addr=9, data=0x00000003 → rf_we pulses at t+1, t+2 with matching addr/data; stall_pipe stays 0.
- Idle port: lu push addr=2, data=0xDEADBEEF with pipe_we=0 → rf_we at t+2 with addr=2; pending 1 for exactly one cycle.
- Starvation: one lu push, then pipe_we=1 every cycle, addr=5 → stall_pipe rises after MAX_WAIT=4 un-granted cycles; the FIFO entry writes; stall_pipe falls; pipeline writes resume.
- Full: two lu pushes back-to-back while pipe_we=1 → lu_ready=0, stall_pipe=1 next cycle, two FIFO writes in order, then NORMAL.
- Register 0: pipe_we=1, addr=0, and a lu push with addr=0 → no rf_we from either; the FIFO entry is popped and pending clears.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for the WriteBack stage.
// Shares the single write port between the in-order pipeline result and
// long-latency (mul/div) results. Long-latency results wait in a small FIFO.
// A starvation guard freezes the pipeline until every buffered result has drained.
module wb_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              stall_pipe,
  output logic              pending,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam int unsigned EntW  = ADDR_W + DATA_W;

  localparam logic [CntW-1:0]  FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  typedef enum logic [0:0] {StNormal, StStall} stateT;

  stateT             stateQ, stateD;
  logic [CntW-1:0]   countQ, countD;
  logic [WaitW-1:0]  waitQ, waitD;
  logic [PtrW-1:0]   rdPtrQ, wrPtrQ;
  logic [EntW-1:0]   fifoMem [FIFO_DEPTH];

  logic              push, pop, pipeGrant;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;
  logic              rfWeD;
  logic [ADDR_W-1:0] rfAddrD;
  logic [DATA_W-1:0] rfDataD;

  // Status outputs come from registered state only, so there is no input-to-output path.
  assign lu_ready   = (countQ < FullCnt);
  assign pending    = (countQ != '0);
  assign stall_pipe = (stateQ == StStall);
  assign push       = lu_valid && lu_ready;
  assign headAddr   = fifoMem[rdPtrQ][EntW-1:DATA_W];
  assign headData   = fifoMem[rdPtrQ][DATA_W-1:0];

  // Grant, FIFO occupancy, starvation counter and next-state decode.
  always_comb begin
    stateD    = stateQ;
    pipeGrant = 1'b0;
    pop       = 1'b0;
    countD    = countQ;
    waitD     = waitQ;
    rfWeD     = 1'b0;
    rfAddrD   = rf_addr;
    rfDataD   = rf_data;

    if (stateQ == StStall) begin
      // Pipeline is frozen and will re-present its write later.
      pop = pending;
    end else begin
      // A write to r0 is not a real request, so the FIFO may use the port.
      pipeGrant = pipe_we && (pipe_addr != '0);
      pop       = !pipeGrant && pending;
    end

    unique case ({push, pop})
      2'b10:   countD = countQ + CntW'(1);
      2'b01:   countD = countQ - CntW'(1);
      default: countD = countQ;
    endcase

    if (!pending || pop) begin
      waitD = '0;
    end else if (waitQ != MaxWait) begin
      waitD = waitQ + WaitW'(1);
    end

    unique case (stateQ)
      StNormal: begin
        if ((waitD == MaxWait) || ((countQ == FullCnt) && !pop)) begin
          stateD = StStall;
        end
      end
      StStall: begin
        if (countD == '0) begin
          stateD = StNormal;
        end
      end
      default: stateD = StNormal;
    endcase

    // Heads targeting r0 are still popped, just never written.
    if (pipeGrant) begin
      rfWeD   = 1'b1;
      rfAddrD = pipe_addr;
      rfDataD = pipe_data;
    end else if (pop && (headAddr != '0)) begin
      rfWeD   = 1'b1;
      rfAddrD = headAddr;
      rfDataD = headData;
    end
  end

  // Control state and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= StNormal;
      countQ  <= '0;
      waitQ   <= '0;
      rdPtrQ  <= '0;
      wrPtrQ  <= '0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      stateQ  <= stateD;
      countQ  <= countD;
      waitQ   <= waitD;
      rf_we   <= rfWeD;
      rf_addr <= rfAddrD;
      rf_data <= rfDataD;
      if (push) wrPtrQ <= wrPtrQ + PtrW'(1);
      if (pop)  rdPtrQ <= rdPtrQ + PtrW'(1);
    end
  end

  // FIFO storage. Not reset; entries are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtrQ] <= {lu_addr, lu_data};
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed timing checks plus an
// in-order scoreboard of expected register-file writes.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        stall_pipe;
  logic        pending;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } expT;

  expT sbQ[$];
  int  total = 0;
  int  bad   = 0;

  wb_port_arbiter #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .FIFO_DEPTH(2),
    .MAX_WAIT  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pipe_we   (pipe_we),
    .pipe_addr (pipe_addr),
    .pipe_data (pipe_data),
    .lu_valid  (lu_valid),
    .lu_addr   (lu_addr),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .stall_pipe(stall_pipe),
    .pending   (pending),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every write pulse must match the next expected write, in order.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      checkVal("sb_avail", 64'(sbQ.size() != 0), 64'(1));
      if (sbQ.size() != 0) begin
        expT e;
        e = sbQ.pop_front();
        checkVal("sb_addr", 64'(rf_addr), 64'(e.a));
        checkVal("sb_data", 64'(rf_data), 64'(e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    #1;
    checkVal("rst_rf_we", 64'(rf_we), 64'(0));
    checkVal("rst_rf_addr", 64'(rf_addr), 64'(0));
    checkVal("rst_rf_data", 64'(rf_data), 64'(0));
    checkVal("rst_stall", 64'(stall_pipe), 64'(0));
    checkVal("rst_pending", 64'(pending), 64'(0));
    checkVal("rst_lu_ready", 64'(lu_ready), 64'(1));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Pipeline only: back-to-back writes, one cycle latency.
    pipe_we = 1'b1; pipe_addr = 5'd8; pipe_data = 32'h1;
    sbQ.push_back('{a: 5'd8, d: 32'h1});
    tick();
    checkVal("pipe_we_t1", 64'(rf_we), 64'(1));
    checkVal("pipe_addr_t1", 64'(rf_addr), 64'(8));
    pipe_addr = 5'd9; pipe_data = 32'h3;
    sbQ.push_back('{a: 5'd9, d: 32'h3});
    tick();
    checkVal("pipe_we_t2", 64'(rf_we), 64'(1));
    checkVal("pipe_addr_t2", 64'(rf_addr), 64'(9));
    checkVal("pipe_stall", 64'(stall_pipe), 64'(0));
    pipe_we = 1'b0;
    tick();
    checkVal("pipe_we_off", 64'(rf_we), 64'(0));
    checkVal("pipe_addr_hold", 64'(rf_addr), 64'(9));

    // Idle port: long-latency result written two cycles after push.
    lu_valid = 1'b1; lu_addr = 5'd2; lu_data = 32'hDEAD_BEEF;
    sbQ.push_back('{a: 5'd2, d: 32'hDEAD_BEEF});
    tick();
    lu_valid = 1'b0;
    checkVal("idle_pending_t1", 64'(pending), 64'(1));
    checkVal("idle_we_t1", 64'(rf_we), 64'(0));
    tick();
    checkVal("idle_we_t2", 64'(rf_we), 64'(1));
    checkVal("idle_addr_t2", 64'(rf_addr), 64'(2));
    checkVal("idle_pending_t2", 64'(pending), 64'(0));
    tick();
    checkVal("idle_we_t3", 64'(rf_we), 64'(0));

    // Starvation: pipeline hogs the port until the guard stalls it.
    lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h1111_2222;
    tick();
    lu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'(i);
      sbQ.push_back('{a: 5'd5, d: 32'(i)});
      tick();
      checkVal("starve_stall", 64'(stall_pipe), 64'(i == 4));
    end
    pipe_data = 32'd5;
    sbQ.push_back('{a: 5'd3, d: 32'h1111_2222});
    tick();
    checkVal("starve_fifo_addr", 64'(rf_addr), 64'(3));
    checkVal("starve_stall_fall", 64'(stall_pipe), 64'(0));
    checkVal("starve_pending", 64'(pending), 64'(0));
    sbQ.push_back('{a: 5'd5, d: 32'd5});
    tick();
    checkVal("starve_resume_we", 64'(rf_we), 64'(1));
    checkVal("starve_resume_addr", 64'(rf_addr), 64'(5));
    pipe_we = 1'b0;
    tick();

    // Full FIFO: two pushes under a busy pipeline force a stall.
    pipe_we = 1'b1; pipe_addr = 5'd6; pipe_data = 32'h60;
    lu_valid = 1'b1; lu_addr = 5'd10; lu_data = 32'hAAAA_0001;
    sbQ.push_back('{a: 5'd6, d: 32'h60});
    tick();
    lu_addr = 5'd11; lu_data = 32'hBBBB_0002; pipe_data = 32'h61;
    sbQ.push_back('{a: 5'd6, d: 32'h61});
    tick();
    lu_valid = 1'b0;
    checkVal("full_lu_ready", 64'(lu_ready), 64'(0));
    checkVal("full_stall_pre", 64'(stall_pipe), 64'(0));
    pipe_data = 32'h62;
    sbQ.push_back('{a: 5'd6, d: 32'h62});
    tick();
    checkVal("full_stall", 64'(stall_pipe), 64'(1));
    checkVal("full_lu_ready_s", 64'(lu_ready), 64'(0));
    pipe_data = 32'h63;
    sbQ.push_back('{a: 5'd10, d: 32'hAAAA_0001});
    tick();
    checkVal("full_first_addr", 64'(rf_addr), 64'(10));
    checkVal("full_stall_hold", 64'(stall_pipe), 64'(1));
    checkVal("full_lu_ready_1", 64'(lu_ready), 64'(1));
    sbQ.push_back('{a: 5'd11, d: 32'hBBBB_0002});
    tick();
    checkVal("full_second_addr", 64'(rf_addr), 64'(11));
    checkVal("full_normal", 64'(stall_pipe), 64'(0));
    checkVal("full_pending", 64'(pending), 64'(0));
    sbQ.push_back('{a: 5'd6, d: 32'h63});
    tick();
    checkVal("full_resume_data", 64'(rf_data), 64'(32'h63));
    pipe_we = 1'b0;
    tick();

    // Register 0: neither source produces a write; FIFO entry still drains.
    pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h99;
    lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h77;
    tick();
    lu_valid = 1'b0;
    checkVal("r0_we_t1", 64'(rf_we), 64'(0));
    checkVal("r0_pending_t1", 64'(pending), 64'(1));
    tick();
    checkVal("r0_we_t2", 64'(rf_we), 64'(0));
    checkVal("r0_pending_t2", 64'(pending), 64'(0));
    pipe_we = 1'b0;
    tick();

    // Reset mid-stream with two entries buffered.
    pipe_we = 1'b1; pipe_addr = 5'd7; pipe_data = 32'h70;
    lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC0;
    sbQ.push_back('{a: 5'd7, d: 32'h70});
    tick();
    pipe_data = 32'h71; lu_addr = 5'd13; lu_data = 32'hD0;
    sbQ.push_back('{a: 5'd7, d: 32'h71});
    tick();
    checkVal("mid_pending", 64'(pending), 64'(1));
    checkVal("mid_lu_ready", 64'(lu_ready), 64'(0));
    #5;
    pipe_we = 1'b0; lu_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkVal("arst_rf_we", 64'(rf_we), 64'(0));
    checkVal("arst_rf_addr", 64'(rf_addr), 64'(0));
    checkVal("arst_rf_data", 64'(rf_data), 64'(0));
    checkVal("arst_stall", 64'(stall_pipe), 64'(0));
    checkVal("arst_pending", 64'(pending), 64'(0));
    checkVal("arst_lu_ready", 64'(lu_ready), 64'(1));
    #10;
    rst_n = 1'b1;
    tick();
    checkVal("post_pending", 64'(pending), 64'(0));
    checkVal("post_lu_ready", 64'(lu_ready), 64'(1));
    checkVal("post_stall", 64'(stall_pipe), 64'(0));
    tick();
    checkVal("post_rf_we", 64'(rf_we), 64'(0));

    checkVal("sb_drained", 64'(sbQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
